grant_busy_sequencer: RTL and testbench

- Producer stage that generates the req/grant/start/busy handshake consumed by the downstream repetition checkers.
- Accepts a request, waits a clamped programmable delay, then pulses grant and start together, and holds busy for a fixed number of consecutive cycles.
- Sits directly upstream of the checker block. It is a drop-in driver, so the checker properties hold by construction.
- One request may be queued while a transaction is in flight.

---
 rtl/grant_busy_pkg.sv | 29 ++
 rtl/sat_down_counter.sv | 53 +++++
 rtl/grant_busy_sequencer.sv | 158 +++++++++++++++
 tb/tb_grant_busy_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/grant_busy_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : grant_busy_pkg                                             |
// | Description : Shared types, default constants and the delay clamp helper |
// |               for the grant/busy handshake sequencer.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package grant_busy_pkg;

  // Sequencer phases; explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2,
    BUSY  = 2'd3
  } state_e;

  localparam int unsigned BUSY_LEN_DEFAULT        = 5;
  localparam int unsigned MIN_GRANT_DELAY_DEFAULT = 3;

  // Effective req-to-grant delay: the requested delay, but never shorter than
  // the minimum. Operates on a generous width; callers size-cast the result.
  function automatic logic [15:0] eff_delay(input logic [15:0] grant_delay,
                                            input logic [15:0] min_delay);
    return (grant_delay < min_delay) ? min_delay : grant_delay;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_down_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sat_down_counter                                           |
// | Description : Loadable down-counter that saturates at zero, with zero    |
// |               and one flags. Load has priority over decrement.           |
// | Ports       : clk, rst       - clock, synchronous active-high reset      |
// |               i_load         - load i_load_val this cycle                |
// |               i_load_val[W]  - value to load                             |
// |               i_dec          - decrement (ignored at zero)               |
// |               o_count[W]     - current count                             |
// |               o_is_zero      - count == 0                                |
// |               o_is_one       - count == 1                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sat_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_is_zero,
  output logic         o_is_one
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (i_dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count   = count_q;
  assign o_is_zero = (count_q == '0);
  assign o_is_one  = (count_q == W'(1));

endmodule
`default_nettype wire

// File: rtl/grant_busy_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : grant_busy_sequencer                                       |
// | Description : Accepts a request, waits a clamped programmable delay,     |
// |               pulses grant/start, then holds busy for BUSY_LEN cycles.   |
// |               One further request can be queued while busy.             |
// | Ports       : clk               - clock, rising edge                     |
// |               rst               - synchronous active-high reset          |
// |               req               - request, sampled every cycle           |
// |               grant_delay[DW]   - requested delay, sampled on accept     |
// |               cancel            - aborts a transaction in WAIT only      |
// |               grant, start      - one-cycle pulse (identical)            |
// |               busy              - BUSY_LEN cycles after start            |
// |               done              - pulse on the last busy cycle           |
// |               pending           - a queued request is waiting            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module grant_busy_sequencer
  import grant_busy_pkg::*;
#(
  parameter int unsigned BUSY_LEN        = BUSY_LEN_DEFAULT,
  parameter int unsigned MIN_GRANT_DELAY = MIN_GRANT_DELAY_DEFAULT,
  parameter int          DELAY_W         = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [DELAY_W-1:0] grant_delay,
  input  logic               cancel,
  output logic               grant,
  output logic               start,
  output logic               busy,
  output logic               done,
  output logic               pending
);

  // Effective delay carries one extra bit so the clamp value always fits.
  localparam int DW    = DELAY_W + 1;
  localparam int BW    = $clog2(BUSY_LEN + 1);
  localparam int CNT_W = (DW > BW) ? DW : BW;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   pending_q, pending_d;

  logic [DW-1:0]    w_eff_d;
  logic [DW-1:0]    w_eff_d_m1;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic             w_cnt_dec;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_is_zero;
  logic             w_cnt_is_one;

  assign w_eff_d    = DW'(eff_delay(16'(grant_delay), 16'(MIN_GRANT_DELAY)));
  assign w_eff_d_m1 = w_eff_d - DW'(1);

  sat_down_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_count    (w_cnt),
    .o_is_zero  (w_cnt_is_zero),
    .o_is_one   (w_cnt_is_one)
  );

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_cnt_dec      = 1'b0;

    case (state_q)
      IDLE: begin
        // A request left queued by the final busy cycle is serviced here.
        if (req || pending_q) begin
          state_d        = WAIT;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = CNT_W'(w_eff_d_m1);
          pending_d      = 1'b0;
        end
      end
      WAIT: begin
        if (cancel) begin
          // Cancel also discards any queued request, including one arriving now.
          state_d   = IDLE;
          pending_d = 1'b0;
        end else begin
          w_cnt_dec = 1'b1;
          if (req) pending_d = 1'b1;
          if (w_cnt_is_one || w_cnt_is_zero) state_d = GRANT;
        end
      end
      GRANT: begin
        state_d        = BUSY;
        w_cnt_load     = 1'b1;
        w_cnt_load_val = CNT_W'(BUSY_LEN);
        if (req) pending_d = 1'b1;
      end
      BUSY: begin
        w_cnt_dec = 1'b1;
        if (req) pending_d = 1'b1;
        if (w_cnt_is_one || w_cnt_is_zero) begin
          // Decision uses pending_q: a req in this same cycle only queues.
          if (pending_q) begin
            state_d        = WAIT;
            w_cnt_load     = 1'b1;
            // Full D here (not D-1): the turnaround includes this boundary cycle.
            w_cnt_load_val = CNT_W'(w_eff_d);
            pending_d      = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    grant_d = (state_d == GRANT);
    busy_d  = (state_d == BUSY);
    // done is registered, so it is raised one cycle ahead of the last busy cycle.
    done_d  = ((state_q == GRANT) && (BUSY_LEN == 1)) ||
              ((state_q == BUSY) && (state_d == BUSY) && (w_cnt == CNT_W'(2)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pending_q <= pending_d;
    end
  end

  assign grant   = grant_q;
  assign start   = grant_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pending = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_grant_busy_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_grant_busy_sequencer                                    |
// | Description : Directed self-checking bench for grant_busy_sequencer.     |
// |               Cycle i of each scenario starts at a rising edge; inputs   |
// |               are driven and outputs sampled on the falling edge.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_grant_busy_sequencer;

  localparam int BUSY_LEN = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [3:0] grant_delay;
  logic       cancel;
  logic       grant, start, busy, done, pending;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  grant_busy_sequencer #(
    .BUSY_LEN        (5),
    .MIN_GRANT_DELAY (3),
    .DELAY_W         (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant_delay (grant_delay),
    .cancel      (cancel),
    .grant       (grant),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .pending     (pending)
  );

  // Invariant monitor, sampled just after each rising edge.
  int   busy_left  = 0;
  logic prev_grant = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      busy_left  = 0;
      prev_grant = 1'b0;
    end else begin
      n_tests++;
      if ((grant && busy) || (grant && prev_grant) || (start !== grant) ||
          (busy_left > 0 && !busy) || (busy_left == 0 && busy)) begin
        n_fail++;
        $display("FAIL invariant at %0t: grant=%b start=%b busy=%b busy_left=%0d prev_grant=%b",
                 $time, grant, start, busy, busy_left, prev_grant);
      end
      if (grant) busy_left = BUSY_LEN;
      else if (busy_left > 0) busy_left--;
      prev_grant = grant;
    end
  end

  task automatic test_reset();
    logic [4:0] obs;
    rst = 1'b1; req = 1'b1; cancel = 1'b0; grant_delay = 4'd0;
    repeat (3) @(negedge clk);
    obs = {grant, start, busy, done, pending};
    n_tests++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want %b", obs, 5'b0);
    end
    rst = 1'b0; req = 1'b0;
    repeat (6) @(negedge clk);
    obs = {grant, start, busy, done, pending};
    n_tests++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_no_accept: got %b want %b", obs, 5'b0);
    end
  endtask

  // req at 10, delay 6: grant 16, busy 17..21, done 21.
  task automatic test_basic();
    logic [4:0] obs, exp;
    for (int i = 0; i <= 24; i++) begin
      obs = {grant, start, busy, done, pending};
      exp = {i == 16, i == 16, (i >= 17 && i <= 21), i == 21, 1'b0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL basic cycle %0d: got %b want %b", i, obs, exp);
      end
      req = (i == 10); cancel = 1'b0; grant_delay = 4'd6;
      @(negedge clk);
    end
  endtask

  // delay 0 clamps to 3; cancel in IDLE, GRANT and BUSY has no effect.
  task automatic test_clamp();
    logic [4:0] obs, exp;
    for (int i = 0; i <= 22; i++) begin
      obs = {grant, start, busy, done, pending};
      exp = {i == 13, i == 13, (i >= 14 && i <= 18), i == 18, 1'b0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL clamp cycle %0d: got %b want %b", i, obs, exp);
      end
      req = (i == 10); cancel = (i == 5 || i == 13 || i == 15); grant_delay = 4'd0;
      @(negedge clk);
    end
  endtask

  // req 10 and 15 (delay 3): pending 16..18, grants 13 and 22.
  task automatic test_queue();
    logic [4:0] obs, exp;
    for (int i = 0; i <= 30; i++) begin
      obs = {grant, start, busy, done, pending};
      exp = {(i == 13 || i == 22), (i == 13 || i == 22),
             ((i >= 14 && i <= 18) || (i >= 23 && i <= 27)),
             (i == 18 || i == 27), (i >= 16 && i <= 18)};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL queue cycle %0d: got %b want %b", i, obs, exp);
      end
      req = (i == 10 || i == 15); cancel = 1'b0; grant_delay = 4'd3;
      @(negedge clk);
    end
  endtask

  // req 10 (delay 8), req+cancel at 12: nothing issued; fresh req at 20 works.
  task automatic test_cancel();
    logic [4:0] obs, exp;
    for (int i = 0; i <= 30; i++) begin
      obs = {grant, start, busy, done, pending};
      exp = {i == 23, i == 23, (i >= 24 && i <= 28), i == 28, 1'b0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL cancel cycle %0d: got %b want %b", i, obs, exp);
      end
      req = (i == 10 || i == 12 || i == 20); cancel = (i == 12);
      grant_delay = (i < 20) ? 4'd8 : 4'd3;
      @(negedge clk);
    end
  endtask

  // rst during third busy cycle (16) with a request queued.
  task automatic test_reset_mid_busy();
    logic [4:0] obs, exp;
    for (int i = 0; i <= 31; i++) begin
      obs = {grant, start, busy, done, pending};
      exp = {(i == 13 || i == 23), (i == 13 || i == 23),
             ((i >= 14 && i <= 16) || (i >= 24 && i <= 28)),
             i == 28, i == 16};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_busy cycle %0d: got %b want %b", i, obs, exp);
      end
      rst = (i == 16); req = (i == 10 || i == 15 || i == 20); cancel = 1'b0;
      grant_delay = 4'd3;
      @(negedge clk);
    end
  endtask

  // req held high 10..49, delay 3: grants every 9 cycles, 13..58.
  task automatic test_back_to_back();
    logic [4:0] obs, exp;
    int         ph;
    int         n_grant;
    n_grant = 0;
    for (int i = 0; i <= 70; i++) begin
      ph  = (i >= 13) ? (i - 13) % 9 : -1;
      obs = {grant, start, busy, done, pending};
      exp = {(i >= 13 && i <= 58 && ph == 0), (i >= 13 && i <= 58 && ph == 0),
             (i >= 14 && i <= 63 && ph >= 1 && ph <= 5),
             (i >= 18 && i <= 63 && ph == 5),
             (i >= 12 && i <= 54 && i != 19 && i != 28 && i != 37 && i != 46)};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %b want %b", i, obs, exp);
      end
      if (grant) n_grant++;
      req = (i >= 10 && i <= 49); cancel = 1'b0; grant_delay = 4'd3;
      @(negedge clk);
    end
    n_tests++;
    if (n_grant !== 6) begin
      n_fail++;
      $display("FAIL back_to_back grant_count: got %0d want %0d", n_grant, 6);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_queue();
    test_cancel();
    test_reset_mid_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
